// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op codes, FSM states,
// and the store / alignment classification functions.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    LOADED = 3'd3,
    RESP   = 3'd4
  } state_e;

  // True for any op that modifies memory.
  function automatic logic is_store(op_e op);
    logic res;
    case (op)
      SW, SH, SB: res = 1'b1;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_aligned(op_e op, logic [1:0] lo);
    logic res;
    case (op)
      LH, LHU, SH: res = (lo[0] == 1'b0);
      LW, SW:      res = (lo == 2'b00);
      default:     res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane logic for the load/store unit: extracts and extends the addressed
// byte/halfword for loads, and merges store data into the old word for
// read-modify-write of sub-word stores. Purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  op_e         op_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign op_s = op_e'(op);

  // Pick the addressed byte and halfword (little-endian lanes).
  always_comb begin
    byte_s = 8'h00;
    case (byte_off)
      2'd0:    byte_s = old_word[7:0];
      2'd1:    byte_s = old_word[15:8];
      2'd2:    byte_s = old_word[23:16];
      2'd3:    byte_s = old_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (byte_off[1]) begin
      half_s = old_word[31:16];
    end else begin
      half_s = old_word[15:0];
    end
  end

  // Sign- or zero-extend the selected lane into the load result.
  always_comb begin
    load_data = old_word;
    case (op_s)
      LB:      load_data = {{24{byte_s[7]}}, byte_s};
      LBU:     load_data = {24'h000000, byte_s};
      LH:      load_data = {{16{half_s[15]}}, half_s};
      LHU:     load_data = {16'h0000, half_s};
      default: load_data = old_word;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    merge_data = old_word;
    case (op_s)
      SB: begin
        case (byte_off)
          2'd0:    merge_data = {old_word[31:8], wdata[7:0]};
          2'd1:    merge_data = {old_word[31:16], wdata[7:0], old_word[7:0]};
          2'd2:    merge_data = {old_word[31:24], wdata[7:0], old_word[15:0]};
          2'd3:    merge_data = {wdata[7:0], old_word[23:0]};
          default: merge_data = old_word;
        endcase
      end
      SH: begin
        if (byte_off[1]) begin
          merge_data = {wdata[15:0], old_word[15:0]};
        end else begin
          merge_data = {old_word[31:16], wdata[15:0]};
        end
      end
      SW:      merge_data = wdata;
      default: merge_data = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: one request at a time, alignment and range checks,
// sign/zero-extended loads and read-modify-write for byte/halfword stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_writeEnable,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);

  // One past the last valid byte address; 33 bits so large memories do not wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_e      state_r;
  op_e         op_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rsp_data_r;
  logic        rsp_err_r;

  op_e         req_op_s;
  logic        req_bad_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  assign req_op_s  = op_e'(req_op);
  assign req_bad_s = !is_aligned(req_op_s, req_addr[1:0]) ||
                     ({1'b0, req_addr} >= ADDR_LIMIT);

  lsu_lane u_lane (
    .op         (op_r),
    .byte_off   (addr_r[1:0]),
    .old_word   (mem_dataOut),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Request FSM: latch on accept, sequence the memory access, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= LW;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      rsp_data_r <= 32'h0000_0000;
      rsp_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r       <= req_op_s;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            rsp_data_r <= 32'h0000_0000;
            rsp_err_r  <= req_bad_s;
            if (req_bad_s) begin
              state_r <= RESP;
            end else if (req_op_s == SW) begin
              state_r <= WRITE;
            end else begin
              state_r <= READ;
            end
          end
        end
        READ:  state_r <= LOADED;
        WRITE: state_r <= RESP;
        LOADED: begin
          if (!is_store(op_r)) begin
            rsp_data_r <= load_data_s;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of state and latched request; quiet in IDLE/RESP.
  always_comb begin
    mem_address     = 32'h0000_0000;
    mem_writeEnable = 1'b0;
    mem_dataIn      = 32'h0000_0000;
    case (state_r)
      READ: begin
        mem_address = {2'b00, addr_r[31:2]};
      end
      WRITE: begin
        mem_address     = {2'b00, addr_r[31:2]};
        mem_writeEnable = 1'b1;
        mem_dataIn      = wdata_r;
      end
      LOADED: begin
        mem_address = {2'b00, addr_r[31:2]};
        if (is_store(op_r)) begin
          mem_writeEnable = 1'b1;
          mem_dataIn      = merge_data_s;
        end else begin
          mem_writeEnable = 1'b0;
          mem_dataIn      = 32'h0000_0000;
        end
      end
      default: begin
        mem_address     = 32'h0000_0000;
        mem_writeEnable = 1'b0;
        mem_dataIn      = 32'h0000_0000;
      end
    endcase
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a one-cycle-latency
// word memory model attached to the memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut = 32'h0000_0000;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .mem_address     (mem_address),
    .mem_writeEnable (mem_writeEnable),
    .mem_dataIn      (mem_dataIn),
    .mem_dataOut     (mem_dataOut)
  );

  always #5 clk = ~clk;

  // Word memory: write on strobe, registered read one cycle later.
  always @(posedge clk) begin
    if (mem_writeEnable) mem[mem_address[9:0]] <= mem_dataIn;
    mem_dataOut <= mem[mem_address[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at the current negedge (LSU idle) and follow it to RESP.
  // Returns at the negedge of the first response cycle.
  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_we_cyc, input logic [31:0] exp_maddr,
                        input logic [31:0] exp_mdin);
    int   cyc;
    int   we_cyc;
    logic got;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc    = 1;
    we_cyc = 0;
    got    = 1'b0;
    while (cyc <= 8 && !got) begin
      if (mem_writeEnable && we_cyc == 0) begin
        we_cyc = cyc;
        check({tag, ":mem_address"}, mem_address, exp_maddr);
        check({tag, ":mem_dataIn"}, mem_dataIn, exp_mdin);
      end
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, ":latency"}, got ? 32'(cyc) : 32'd99, 32'(exp_lat));
    check({tag, ":we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
    check({tag, ":rsp_data"}, rsp_data, exp_data);
    check({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  // Step past the response handshake and confirm the LSU is idle again.
  task automatic finish_rsp(input string tag);
    @(negedge clk);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    check({tag, ":valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    // Reset with random inputs: outputs must sit at reset values.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom);
      req_op    = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      rsp_ready = 1'($urandom);
      @(negedge clk);
    end
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_data", rsp_data, 32'd0);
    check("rst:rsp_err", 32'(rsp_err), 32'd0);
    check("rst:mem_we", 32'(mem_writeEnable), 32'd0);
    check("rst:mem_address", mem_address, 32'd0);
    check("rst:mem_dataIn", mem_dataIn, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    check("idle:req_ready", 32'(req_ready), 32'd1);
    check("idle:rsp_valid", 32'(rsp_valid), 32'd0);

    // Full-word store then load back.
    do_req("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'd4, 32'hDEADBEEF);
    finish_rsp("sw10");
    do_req("lw10", OP_LW, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lw10");

    // Byte store via read-modify-write, then lane loads.
    do_req("sb12", OP_SB, 32'h12, 32'h11, 3, 32'h0, 1'b0, 2, 32'd4, 32'hDE11BEEF);
    finish_rsp("sb12");
    do_req("lw10b", OP_LW, 32'h10, 32'h0, 3, 32'hDE11BEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lw10b");
    do_req("lbu13", OP_LBU, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lbu13");
    do_req("lhu10", OP_LHU, 32'h10, 32'h0, 3, 32'h0000BEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lhu10");
    do_req("lh10", OP_LH, 32'h10, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lh10");

    // Misaligned and out-of-range requests fault without touching memory.
    do_req("lh11", OP_LH, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
    finish_rsp("lh11");
    do_req("sw16", OP_SW, 32'h16, 32'h12345678, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
    finish_rsp("sw16");
    do_req("lw1000", OP_LW, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
    finish_rsp("lw1000");

    // Stall the response for 5 cycles after LB 0x13.
    rsp_ready = 1'b0;
    do_req("lb13", OP_LB, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall:rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall:rsp_data", rsp_data, 32'hFFFFFFDE);
      check("stall:rsp_err", 32'(rsp_err), 32'd0);
      check("stall:req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    finish_rsp("stall");
    // Back-to-back request in the very first idle cycle.
    do_req("b2b_lw", OP_LW, 32'h10, 32'h0, 3, 32'hDE11BEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("b2b_lw");

    // SH with reset pulsed during LOADED: the write must not happen.
    req_op    = OP_SH;
    req_addr  = 32'h12;
    req_wdata = 32'hAAAA;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("shrst:we_loaded", 32'(mem_writeEnable), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("shrst:we_dropped", 32'(mem_writeEnable), 32'd0);
    check("shrst:req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req("lw_after_rst", OP_LW, 32'h10, 32'h0, 3, 32'hDE11BEEF, 1'b0, 0, 32'd0, 32'd0);
    finish_rsp("lw_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
